chord_round_ctrl: RTL and testbench
===================================

Name: chord_round_ctrl

Overview:
- Game sequencer for the chord trainer, sitting between the board inputs and vga_bitchange.
- Picks a pseudo-random major/minor triad each round and exposes it as a 12-bit note mask (bit0=C … bit11=B).
- Times each round, checks the player's switch mask against the target, and keeps score, round number and remaining time for the display path.
- Runs NUM_ROUNDS rounds per game, then holds a game-over state until restarted.

Parameters:
- TICK_DIV, 25000000, clk cycles per game tick (4 Hz at 100 MHz).
- ROUND_TICKS, 20, ticks allowed per round; range 1..255.
- RESULT_TICKS, 4, ticks the result is shown before the next round; range ≥1.
- NUM_ROUNDS, 8, rounds per game; range 1..15.
- MATCH_HOLD, 1000000, consecutive cycles the switches must equal the target to count as a hit; range ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse, already debounced; starts or restarts a game.
- keySelect  in  12  raw switch mask; asynchronous to clk.
- target_mask  out  12  current target chord mask.
- show_target  out  1  high in PLAY and RESULT.
- score  out  8  points this game; saturates at 255.
- round_num  out  4  current round, 1-based; 0 in IDLE.
- time_left  out  8  ticks remaining in PLAY.
- hit_pulse  out  1  one-cycle pulse on a hit.
- miss_pulse  out  1  one-cycle pulse on a timeout.
- game_over  out  1  high in DONE.
- busy  out  1  high in LOAD, PLAY and RESULT.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - LFSR = 16'hACE1; divider, match counter and streak counter = 0.
  - Reset mid-game abandons the game immediately; no pulse is emitted.
- Switch sync: keySelect passes through a two-flop synchronizer, giving 2-cycle latency. All compares use the synchronized value.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Steps every cycle in every state.
  - Chord generation is sampled in LOAD:
    - root = lfsr[3:0], minus 12 if ≥12.
    - qual = lfsr[4]: 0 = major base 12'h091, 1 = minor base 12'h089.
    - target_mask = base rotated left by root within 12 bits.
- Tick: the divider counts 0..TICK_DIV-1 and is cleared in LOAD and RESULT entry. tick is a one-cycle strobe when the divider equals TICK_DIV-1.
- FSM:
  - IDLE: on start, clear score and streak, set round_num=0, go to LOAD.
  - LOAD (1 cycle):
    - Generate target, round_num+1.
    - time_left=ROUND_TICKS, match counter=0, clear divider.
    - Go to PLAY.
  - PLAY:
    - Match counter increments while sync_keys==target_mask and clears otherwise.
    - Hit: counter reaches MATCH_HOLD. Score +1 (saturating), streak +1, go to RESULT, hit_pulse in the first RESULT cycle.
    - On tick, time_left−1. If time_left becomes 0: streak=0, go to RESULT, miss_pulse in the first RESULT cycle.
    - If a hit and a timeout occur in the same cycle, the hit wins.
    - PLAY lasts exactly ROUND_TICKS*TICK_DIV cycles absent a hit.
  - RESULT:
    - Target stays displayed.
    - After RESULT_TICKS ticks: go to DONE if round_num==NUM_ROUNDS, else LOAD.
  - DONE: game_over=1. start goes to IDLE behaviour (clear, then LOAD in the next cycle).
- start is ignored in LOAD, PLAY and RESULT.
- The score written on the final round is visible in DONE.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined:
  - A hit whose updated streak ≥3 awards +2 instead of +1, still saturating at 255.
  - Adds output streak (4 bits, saturating at 15, reset 0, cleared on miss and on game start).
- Undefined:
  - Every hit awards +1.
  - No streak port exists; the internal streak counter may be removed.

Test Plan (TICK_DIV=4, ROUND_TICKS=5, RESULT_TICKS=2, NUM_ROUNDS=2, MATCH_HOLD=3):
- Reset check: reset high for 3 cycles, then release → all outputs 0, FSM in IDLE, and the first LOAD after start uses LFSR seed 16'hACE1.
- Timeout: start, keySelect=0 → miss_pulse exactly 20 cycles after PLAY entry, score=0, time_left steps 5→0 once every 4 cycles.
- Hit: start, drive keySelect=target_mask as soon as show_target rises → hit_pulse 2+3 cycles later, score=1, busy stays 1.
- Match glitch: hold the match 2 cycles, drop for 1 cycle, then re-hold → no hit until 3 consecutive synced matches.
- Full game: 2 hits → game_over=1, round_num=2, score=2. start in DONE → score=0, round_num=1 two cycles later.
- Reset mid-PLAY: assert reset with time_left=3 → next cycle all outputs 0, no pulse. With STREAK_BONUS_EN, hits 1/2/3 give score 1/2/4.

Source files
------------

// File: rtl/chord_round_ctrl.sv
// chord_round_ctrl: round sequencer for the chord trainer.
// Picks a pseudo-random major/minor triad per round, times the round, checks
// the synchronized switch mask against the target and keeps score/round/time.
// Optional build macro: STREAK_BONUS_EN (streak output and +2 bonus on streak >= 3).
module chord_round_ctrl #(
    parameter int TICK_DIV     = 25000000,
    parameter int ROUND_TICKS  = 20,
    parameter int RESULT_TICKS = 4,
    parameter int NUM_ROUNDS   = 8,
    parameter int MATCH_HOLD   = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] keySelect,
    output logic [11:0] target_mask,
    output logic        show_target,
    output logic [7:0]  score,
    output logic [3:0]  round_num,
    output logic [7:0]  time_left,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        game_over,
`ifdef STREAK_BONUS_EN
    output logic [3:0]  streak,
`endif
    output logic        busy
);

    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MATCH_W = $clog2(MATCH_HOLD + 1);
    localparam int RES_W   = $clog2(RESULT_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One step of the 16-bit Galois LFSR (x^16+x^14+x^13+x^11, right shifting)
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Triad mask: root from low nibble folded into 0..11, quality from bit 4
    function automatic logic [11:0] chord_from_lfsr(input logic [15:0] seed);
        logic [3:0]  root;
        logic [11:0] base;
        logic [23:0] wide;
        root = (seed[3:0] >= 4'd12) ? (seed[3:0] - 4'd12) : seed[3:0];
        base = seed[4] ? 12'h089 : 12'h091;
        wide = {base, base} << root;
        return wide[23:12];
    endfunction

    state_t               state_r, state_nxt_s;
    logic [11:0]          key_meta_r, key_sync_r;
    logic [15:0]          lfsr_r;
    logic [DIV_W-1:0]     div_r;
    logic [MATCH_W-1:0]   match_cnt_r;
    logic [RES_W-1:0]     res_cnt_r;
    logic [11:0]          target_mask_r;
    logic [7:0]           score_r, time_left_r;
    logic [3:0]           round_num_r;
    logic                 hit_pulse_r, miss_pulse_r, show_target_r, game_over_r, busy_r;
    logic                 tick_s, keys_match_s, hit_s, timeout_s, res_done_s;
    logic [7:0]           score_inc_s, score_hit_s;
    logic [8:0]           score_sum_s;
`ifdef STREAK_BONUS_EN
    logic [3:0]           streak_r, streak_hit_s;
`endif

    assign tick_s       = (div_r == DIV_W'(TICK_DIV - 1));
    assign keys_match_s = (key_sync_r == target_mask_r);
    assign hit_s        = (state_r == ST_PLAY) && keys_match_s &&
                          (match_cnt_r == MATCH_W'(MATCH_HOLD - 1));
    assign timeout_s    = (state_r == ST_PLAY) && tick_s && (time_left_r == 8'd1);
    assign res_done_s   = (state_r == ST_RESULT) && tick_s &&
                          (res_cnt_r == RES_W'(RESULT_TICKS - 1));

    // Two-flop synchronizer for the asynchronous switch mask
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_r <= 12'h000;
            key_sync_r <= 12'h000;
        end else begin
            key_meta_r <= keySelect;
            key_sync_r <= key_meta_r;
        end
    end

    // Free-running chord LFSR, stepping every cycle in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Tick divider, restarted on round load and on entry to the result phase
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= {DIV_W{1'b0}};
        end else if ((state_r == ST_LOAD) || ((state_r == ST_PLAY) && (state_nxt_s == ST_RESULT))) begin
            div_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; a hit outranks a simultaneous timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = state_r;
            end
            ST_LOAD: state_nxt_s = ST_PLAY;
            ST_PLAY: begin
                if (hit_s || timeout_s) state_nxt_s = ST_RESULT;
                else                    state_nxt_s = ST_PLAY;
            end
            ST_RESULT: begin
                if (res_done_s) begin
                    if (round_num_r == 4'(NUM_ROUNDS)) state_nxt_s = ST_DONE;
                    else                               state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Score after a hit, with optional streak bonus and saturation at 255
    always_comb begin
        score_inc_s = 8'd1;
`ifdef STREAK_BONUS_EN
        streak_hit_s = (streak_r == 4'd15) ? 4'd15 : (streak_r + 4'd1);
        if (streak_hit_s >= 4'd3) score_inc_s = 8'd2;
        else                      score_inc_s = 8'd1;
`endif
        score_sum_s = {1'b0, score_r} + {1'b0, score_inc_s};
        if (score_sum_s[8]) score_hit_s = 8'hFF;
        else                score_hit_s = score_sum_s[7:0];
    end

    // Round datapath and registered display/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            target_mask_r <= 12'h000;
            round_num_r   <= 4'd0;
            score_r       <= 8'd0;
            time_left_r   <= 8'd0;
            match_cnt_r   <= {MATCH_W{1'b0}};
            res_cnt_r     <= {RES_W{1'b0}};
            hit_pulse_r   <= 1'b0;
            miss_pulse_r  <= 1'b0;
            show_target_r <= 1'b0;
            game_over_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            hit_pulse_r   <= hit_s;
            miss_pulse_r  <= timeout_s & ~hit_s;
            show_target_r <= (state_nxt_s == ST_PLAY) || (state_nxt_s == ST_RESULT);
            busy_r        <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_PLAY) ||
                             (state_nxt_s == ST_RESULT);
            game_over_r   <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        score_r     <= 8'd0;
                        round_num_r <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    target_mask_r <= chord_from_lfsr(lfsr_r);
                    round_num_r   <= round_num_r + 4'd1;
                    time_left_r   <= 8'(ROUND_TICKS);
                    match_cnt_r   <= {MATCH_W{1'b0}};
                    res_cnt_r     <= {RES_W{1'b0}};
                end
                ST_PLAY: begin
                    if (keys_match_s) match_cnt_r <= match_cnt_r + MATCH_W'(1);
                    else              match_cnt_r <= {MATCH_W{1'b0}};
                    if (tick_s && (time_left_r != 8'd0)) time_left_r <= time_left_r - 8'd1;
                    if (hit_s) score_r <= score_hit_s;
                end
                ST_RESULT: begin
                    if (tick_s) res_cnt_r <= res_cnt_r + RES_W'(1);
                end
                default: begin
                    round_num_r <= round_num_r;
                end
            endcase
        end
    end

`ifdef STREAK_BONUS_EN
    // Consecutive-hit streak, cleared on a miss and at game start
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_r <= 4'd0;
        end else if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start) begin
            streak_r <= 4'd0;
        end else if (hit_s) begin
            streak_r <= streak_hit_s;
        end else if (timeout_s) begin
            streak_r <= 4'd0;
        end else begin
            streak_r <= streak_r;
        end
    end

    assign streak = streak_r;
`endif

    assign target_mask = target_mask_r;
    assign show_target = show_target_r;
    assign score       = score_r;
    assign round_num   = round_num_r;
    assign time_left   = time_left_r;
    assign hit_pulse   = hit_pulse_r;
    assign miss_pulse  = miss_pulse_r;
    assign game_over   = game_over_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_chord_round_ctrl.sv
// Directed self-checking bench for chord_round_ctrl with small timing parameters
// (TICK_DIV=4, ROUND_TICKS=5, RESULT_TICKS=2, NUM_ROUNDS=2, MATCH_HOLD=3).
module tb_chord_round_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] keySelect;
    logic [11:0] target_mask;
    logic        show_target;
    logic [7:0]  score;
    logic [3:0]  round_num;
    logic [7:0]  time_left;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        game_over;
    logic        busy;
`ifdef STREAK_BONUS_EN
    logic [3:0]  streak;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] lfsr_m;
    logic [11:0] exp_t;
    int          n;

    chord_round_ctrl #(
        .TICK_DIV(4), .ROUND_TICKS(5), .RESULT_TICKS(2), .NUM_ROUNDS(2), .MATCH_HOLD(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .keySelect(keySelect),
        .target_mask(target_mask), .show_target(show_target), .score(score),
        .round_num(round_num), .time_left(time_left), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .game_over(game_over),
`ifdef STREAK_BONUS_EN
        .streak(streak),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR stepped alongside the design from the reset seed
    always @(posedge clk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [11:0] model_chord(input logic [15:0] v);
        int          root;
        logic [11:0] base;
        logic [11:0] r;
        root = int'(v[3:0]);
        if (root >= 12) root = root - 12;
        base = v[4] ? 12'h089 : 12'h091;
        r = 12'h000;
        for (int b = 0; b < 12; b++) if (base[b]) r[(b + root) % 12] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_target"}, 32'(target_mask), 32'h0);
        check({tag, "_show"},   32'(show_target), 32'h0);
        check({tag, "_score"},  32'(score),       32'h0);
        check({tag, "_round"},  32'(round_num),   32'h0);
        check({tag, "_time"},   32'(time_left),   32'h0);
        check({tag, "_hit"},    32'(hit_pulse),   32'h0);
        check({tag, "_miss"},   32'(miss_pulse),  32'h0);
        check({tag, "_over"},   32'(game_over),   32'h0);
        check({tag, "_busy"},   32'(busy),        32'h0);
`ifdef STREAK_BONUS_EN
        check({tag, "_streak"}, 32'(streak),      32'h0);
`endif
    endtask

    // Advance until the LOAD cycle (busy without target shown), bounded
    task automatic wait_load(output int cnt);
        cnt = 0;
        while (!(busy === 1'b1 && show_target === 1'b0) && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (game_over !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; keySelect = 12'h000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_zero("rst");
        @(negedge clk);
        check_zero("idle");

        // Game 1, round 1: LFSR from seed gives 0x7138 at LOAD -> minor on root 8
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("g1_load_busy",  32'(busy),        32'd1);
        check("g1_load_show",  32'(show_target), 32'd0);
        check("g1_load_round", 32'(round_num),   32'd0);
        @(negedge clk);
        check("g1r1_target", 32'(target_mask), 32'h908);
        check("g1r1_show",   32'(show_target), 32'd1);
        check("g1r1_round",  32'(round_num),   32'd1);

        // Timeout: time_left steps 5..1 every 4 cycles, miss 20 cycles after PLAY entry
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check("to_time",   32'(time_left),  32'(5 - k / 4));
            check("to_nomiss", 32'(miss_pulse), 32'd0);
        end
        @(negedge clk);
        check("to_miss",  32'(miss_pulse), 32'd1);
        check("to_hit",   32'(hit_pulse),  32'd0);
        check("to_score", 32'(score),      32'd0);
        check("to_time0", 32'(time_left),  32'd0);
        check("to_show",  32'(show_target), 32'd1);
        check("to_busy",  32'(busy),       32'd1);

        // Game 1, round 2: immediate hold of the target
        wait_load(n);
        check("g1r2_result_len", 32'(n), 32'd8);
        exp_t = model_chord(lfsr_m);
        @(negedge clk);
        check("g1r2_target", 32'(target_mask), 32'(exp_t));
        check("g1r2_round",  32'(round_num),   32'd2);
        check("g1r2_time",   32'(time_left),   32'd5);
        keySelect = exp_t;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("hit_early", 32'(hit_pulse), 32'd0);
        end
        @(negedge clk);
        check("hit_pulse", 32'(hit_pulse),  32'd1);
        check("hit_miss",  32'(miss_pulse), 32'd0);
        check("hit_score", 32'(score),      32'd1);
        check("hit_busy",  32'(busy),       32'd1);
        keySelect = 12'h000;
        @(negedge clk);
        check("hit_once", 32'(hit_pulse), 32'd0);
        wait_done(n);
        check("g1_done_wait",  32'(n),         32'd7);
        check("g1_done_over",  32'(game_over), 32'd1);
        check("g1_done_round", 32'(round_num), 32'd2);
        check("g1_done_score", 32'(score),     32'd1);
        check("g1_done_busy",  32'(busy),      32'd0);

        // Game 2: restart from DONE, round 1 with a glitched match
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("g2_load_score", 32'(score),     32'd0);
        check("g2_load_round", 32'(round_num), 32'd0);
        check("g2_load_over",  32'(game_over), 32'd0);
        exp_t = model_chord(lfsr_m);
        @(negedge clk);
        check("g2r1_round",  32'(round_num),   32'd1);
        check("g2r1_target", 32'(target_mask), 32'(exp_t));
        keySelect = exp_t;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (k == 2) keySelect = 12'h000;
            else        keySelect = exp_t;
            check("glitch_nohit", 32'(hit_pulse), 32'd0);
        end
        @(negedge clk);
        check("glitch_hit",   32'(hit_pulse), 32'd1);
        check("glitch_score", 32'(score),     32'd1);
        keySelect = 12'h000;

        // Game 2, round 2: second hit ends the game with score 2
        wait_load(n);
        check("g2r2_result_len", 32'(n), 32'd8);
        exp_t = model_chord(lfsr_m);
        @(negedge clk);
        check("g2r2_target", 32'(target_mask), 32'(exp_t));
        keySelect = exp_t;
        repeat (5) @(negedge clk);
        check("g2r2_hit",   32'(hit_pulse), 32'd1);
        check("g2r2_score", 32'(score),     32'd2);
        keySelect = 12'h000;
        wait_done(n);
        check("g2_done_wait",  32'(n),         32'd8);
        check("g2_done_over",  32'(game_over), 32'd1);
        check("g2_done_round", 32'(round_num), 32'd2);
        check("g2_done_score", 32'(score),     32'd2);
`ifdef STREAK_BONUS_EN
        check("g2_done_streak", 32'(streak), 32'd2);
`endif

        // Game 3: start ignored during PLAY, then reset with time_left=3
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("g3_round", 32'(round_num), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b1;
            else        start = 1'b0;
        end
        check("g3_time3", 32'(time_left), 32'd3);
        check("g3_round_kept", 32'(round_num), 32'd1);
        check("g3_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("post_rst_miss", 32'(miss_pulse), 32'd0);
            check("post_rst_busy", 32'(busy),       32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
